// File: rtl/i2c_slave_regfile.sv
// rtl/i2c_slave_regfile.sv - I2C target with fixed address and pointer-addressed register file
`timescale 1ns/1ps

module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR   = 7'h50,
  parameter int         ADDRESSWIDTH = 4,
  parameter int         DATAWIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    i2c_reset_n,
  input  logic                    scl_in,
  input  logic                    sda_in,
  output logic                    sda_oe,
  input  logic [ADDRESSWIDTH-1:0] host_rd_addr,
  output logic [DATAWIDTH-1:0]    host_rd_data,
  output logic                    wr_strobe,
  output logic [ADDRESSWIDTH-1:0] wr_index,
  output logic [DATAWIDTH-1:0]    wr_byte,
  output logic                    busy
);

  localparam int DEPTH = 1 << ADDRESSWIDTH;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_RX_PTR    = 4'd3;
  localparam logic [3:0] ST_RX_DATA   = 4'd4;
  localparam logic [3:0] ST_RX_ACK    = 4'd5;
  localparam logic [3:0] ST_TX_BYTE   = 4'd6;
  localparam logic [3:0] ST_TX_ACKCHK = 4'd7;
  localparam logic [3:0] ST_IGNORE    = 4'd8;

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  // Sync flops reset high to match an idle bus, so no false edge follows reset.
  always_ff @(posedge clk or negedge i2c_reset_n) begin
    if (!i2c_reset_n) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl_in;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;

  logic [3:0]              state;
  logic [2:0]              bit_cnt;
  logic [DATAWIDTH-1:0]    sh;
  logic [ADDRESSWIDTH-1:0] ptr;
  logic                    rw;
  logic                    ack_half;
  logic [DATAWIDTH-1:0]    regs [DEPTH];

  logic [DATAWIDTH-1:0]    byte_in;
  logic [ADDRESSWIDTH-1:0] ptr_inc;

  assign byte_in      = {sh[DATAWIDTH-2:0], sda_s2};
  assign ptr_inc      = ptr + ADDRESSWIDTH'(1);
  assign host_rd_data = regs[host_rd_addr];

  always_ff @(posedge clk or negedge i2c_reset_n) begin
    if (!i2c_reset_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= 3'd0;
      sh        <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      ack_half  <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_index  <= '0;
      wr_byte   <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      // Bus conditions override any SCL edge seen in the same cycle.
      if (stop_det) begin
        state    <= ST_IDLE;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        bit_cnt  <= 3'd0;
        ack_half <= 1'b0;
      end else if (start_det) begin
        state    <= ST_ADDR;
        sda_oe   <= 1'b0;
        bit_cnt  <= 3'd0;
        ack_half <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              sh      <= byte_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (byte_in[DATAWIDTH-1:1] == SLAVE_ADDR) begin
                  busy  <= 1'b1;
                  rw    <= byte_in[0];
                  state <= ST_ADDR_ACK;
                end else begin
                  busy  <= 1'b0;
                  state <= ST_IGNORE;
                end
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_half) begin
                sda_oe   <= 1'b1;
                ack_half <= 1'b1;
              end else begin
                ack_half <= 1'b0;
                bit_cnt  <= 3'd0;
                if (rw) begin
                  // The fall that ends the ACK also presents the first read bit.
                  sh     <= regs[ptr];
                  sda_oe <= ~regs[ptr][DATAWIDTH-1];
                  state  <= ST_TX_BYTE;
                end else begin
                  sda_oe <= 1'b0;
                  state  <= ST_RX_PTR;
                end
              end
            end
          end
          ST_RX_PTR: begin
            if (scl_rise) begin
              sh      <= byte_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ptr   <= byte_in[ADDRESSWIDTH-1:0];
                state <= ST_RX_ACK;
              end
            end
          end
          ST_RX_DATA: begin
            if (scl_rise) begin
              sh      <= byte_in;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                regs[ptr] <= byte_in;
                wr_strobe <= 1'b1;
                wr_index  <= ptr;
                wr_byte   <= byte_in;
                ptr       <= ptr_inc;
                state     <= ST_RX_ACK;
              end
            end
          end
          ST_RX_ACK: begin
            if (scl_fall) begin
              if (!ack_half) begin
                sda_oe   <= 1'b1;
                ack_half <= 1'b1;
              end else begin
                sda_oe   <= 1'b0;
                ack_half <= 1'b0;
                bit_cnt  <= 3'd0;
                state    <= ST_RX_DATA;
              end
            end
          end
          ST_TX_BYTE: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_oe  <= 1'b0;
                bit_cnt <= 3'd0;
                state   <= ST_TX_ACKCHK;
              end else begin
                sda_oe  <= ~sh[DATAWIDTH-2];
                sh      <= {sh[DATAWIDTH-2:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
          ST_TX_ACKCHK: begin
            // ack_half marks an ACK already seen, waiting for the fall to drive bit 7.
            if (scl_rise && !ack_half) begin
              ptr <= ptr_inc;
              if (!sda_s2) begin
                sh       <= regs[ptr_inc];
                ack_half <= 1'b1;
              end else begin
                state <= ST_IGNORE;
              end
            end else if (scl_fall && ack_half) begin
              sda_oe   <= ~sh[DATAWIDTH-1];
              ack_half <= 1'b0;
              bit_cnt  <= 3'd0;
              state    <= ST_TX_BYTE;
            end
          end
          ST_IDLE, ST_IGNORE: begin
            sda_oe <= 1'b0;
          end
          default: begin
            sda_oe <= 1'b0;
            state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
